// File: rtl/sigdelay_ctrl.sv
// sigdelay_ctrl: sequencer for the sigdelay audio delay line.
// Produces the sample-rate write strobe, drives the delay offset and
// tracks how much of the delay buffer has been filled with real samples.
// Optional feature macro: SIGDELAY_OFFSET_SLEW_EN
//   defined   -> offset walks one step per write strobe toward target_offset
//   undefined -> offset follows target_offset with one cycle of latency
module sigdelay_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DIV_WIDTH-1:0]     sample_div,
    input  logic [ADDRESS_WIDTH-1:0] target_offset,
    output logic                     wr,
    output logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     valid,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0]     DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = {ADDRESS_WIDTH{1'b1}};

    state_t                     state;
    logic [DIV_WIDTH-1:0]       div_cnt;
    logic [ADDRESS_WIDTH-1:0]   fill_cnt;

    // Slew is in progress whenever the driven offset differs from the request.
    assign busy = (offset != target_offset);

    // Sample-rate divider: >= compare lets a lowered sample_div act at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            wr      <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            wr      <= 1'b0;
        end else if (div_cnt >= sample_div) begin
            div_cnt <= '0;
            wr      <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
            wr      <= 1'b0;
        end
    end

    // Fill tracking: counts written samples, saturates, restarts in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt <= '0;
        end else if (state == IDLE) begin
            fill_cnt <= '0;
        end else if (wr && (fill_cnt != FILL_MAX)) begin
            fill_cnt <= fill_cnt + ADDR_ONE;
        end else begin
            fill_cnt <= fill_cnt;
        end
    end

`ifdef SIGDELAY_OFFSET_SLEW_EN
    // Offset slews one sample per write strobe toward the request; direction
    // is re-evaluated every step, and stepping stops at target so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset <= '0;
        end else if (wr && en) begin
            if (offset < target_offset) begin
                offset <= offset + ADDR_ONE;
            end else if (offset > target_offset) begin
                offset <= offset - ADDR_ONE;
            end else begin
                offset <= offset;
            end
        end else begin
            offset <= offset;
        end
    end
`else
    // Offset follows the request every clock, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset <= '0;
        end else begin
            offset <= target_offset;
        end
    end
`endif

    // Fill-state sequencer; compares use the pre-increment fill count and
    // valid is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FILL;
                    valid <= 1'b0;
                end
                FILL: begin
                    if (fill_cnt >= offset) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end else begin
                        state <= FILL;
                        valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (offset > fill_cnt) begin
                        state <= FILL;
                        valid <= 1'b0;
                    end else begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigdelay_ctrl.sv
// Self-checking bench for sigdelay_ctrl: table-driven divider/fill vectors
// plus hand-written sequences for delay growth and divider retiming.
module tb_sigdelay_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] sample_div;
    logic [8:0]  target_offset;
    logic        wr;
    logic [8:0]  offset;
    logic        valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          sel;   // 0 wr, 1 valid, 2 offset, 3 busy
        logic [31:0] exp;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] sd;
        logic [8:0]  tgt;
        int          n;
    } vec_t;
    vec_t vecs[5];

    sigdelay_ctrl #(.ADDRESS_WIDTH(9), .DIV_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sample_div    (sample_div),
        .target_offset (target_offset),
        .wr            (wr),
        .offset        (offset),
        .valid         (valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] act_of(int sel);
        case (sel)
            0:       return {31'd0, wr};
            1:       return {31'd0, valid};
            2:       return {23'd0, offset};
            default: return {31'd0, busy};
        endcase
    endfunction

    function automatic string name_of(int sel);
        case (sel)
            0:       return "wr";
            1:       return "valid";
            2:       return "offset";
            default: return "busy";
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp, int cyc);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_out(int sel, logic [31:0] e, int cyc);
        exp_t it;
        it.sel = sel;
        it.exp = e;
        it.cyc = cyc;
        sb.push_back(it);
    endtask

    // One clock: edge, then compare everything queued for this cycle.
    task automatic step();
        exp_t it;
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(name_of(it.sel), act_of(it.sel), it.exp, it.cyc);
        end
    endtask

    initial begin
        int p;
        vecs[0] = '{sd: 16'd3, tgt: 9'd0, n: 13};
        vecs[1] = '{sd: 16'd0, tgt: 9'd5, n: 10};
        vecs[2] = '{sd: 16'd0, tgt: 9'd0, n: 4};
        vecs[3] = '{sd: 16'd2, tgt: 9'd3, n: 16};
        vecs[4] = '{sd: 16'd1, tgt: 9'd1, n: 8};

        rst           = 1'b0;
        en            = 1'b0;
        sample_div    = 16'd0;
        target_offset = 9'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_wr",     {31'd0, wr},     32'd0, 0);
        check("rst_offset", {23'd0, offset}, 32'd0, 0);
        check("rst_valid",  {31'd0, valid},  32'd0, 0);
        check("rst_busy",   {31'd0, busy},   32'd0, 0);
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            expect_out(0, 32'd0, c);
            expect_out(1, 32'd0, c);
            expect_out(2, 32'd0, c);
            expect_out(3, 32'd0, c);
            step();
        end

`ifdef SIGDELAY_OFFSET_SLEW_EN
        // Slew: offset walks 0 -> 4 one step per write strobe
        target_offset = 9'd4;
        sample_div    = 16'd0;
        en            = 1'b1;
        check("slew_busy_req", {31'd0, busy}, 32'd1, 0);
        for (int c = 1; c <= 7; c++) begin
            expect_out(2, (c - 1 < 4) ? 32'(c - 1) : 32'd4, c);
            expect_out(3, (c - 1 < 4) ? 32'd1 : 32'd0, c);
            step();
        end
`endif

        // Table: divider cadence and fill/valid timing from a clean IDLE
        foreach (vecs[i]) begin
            p             = int'(vecs[i].sd) + 1;
            en            = 1'b0;
            sample_div    = vecs[i].sd;
            target_offset = vecs[i].tgt;
            expect_out(0, 32'd0, 0);
            expect_out(1, 32'd0, 0);
`ifndef SIGDELAY_OFFSET_SLEW_EN
            expect_out(2, 32'(vecs[i].tgt), 0);
            expect_out(3, 32'd0, 0);
`endif
            step();
            en = 1'b1;
            for (int c = 1; c <= vecs[i].n; c++) begin
                expect_out(0, (c % p == 0) ? 32'd1 : 32'd0, c);
`ifndef SIGDELAY_OFFSET_SLEW_EN
                expect_out(1, ((c >= 2) && ((c - 2) / p >= int'(vecs[i].tgt))) ? 32'd1 : 32'd0, c);
                expect_out(3, 32'd0, c);
`endif
                step();
            end
        end

`ifndef SIGDELAY_OFFSET_SLEW_EN
        // Delay grows past the written data while in RUN: back to FILL, then RUN again
        en            = 1'b0;
        sample_div    = 16'd0;
        target_offset = 9'd20;
        expect_out(1, 32'd0, 0);
        step();
        en = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            expect_out(1, (c >= 22) ? 32'd1 : 32'd0, c);
            step();
        end
        target_offset = 9'd100;
        #1;
        check("grow_busy_now", {31'd0, busy}, 32'd1, 22);
        expect_out(1, 32'd1, 23);
        expect_out(2, 32'd100, 23);
        expect_out(3, 32'd0, 23);
        step();
        for (int c = 24; c <= 103; c++) begin
            expect_out(1, (c >= 102) ? 32'd1 : 32'd0, c);
            step();
        end
        // Dropping en takes valid low on the next cycle
        en = 1'b0;
        expect_out(1, 32'd0, 104);
        expect_out(0, 32'd0, 104);
        step();
`endif

        // Divider retiming: sample_div lowered 100 -> 2 with div_cnt at 50
        en         = 1'b0;
        sample_div = 16'd100;
        expect_out(0, 32'd0, 0);
        step();
        en = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            expect_out(0, 32'd0, c);
            step();
        end
        sample_div = 16'd2;
        for (int c = 51; c <= 60; c++) begin
            expect_out(0, ((c - 51) % 3 == 0) ? 32'd1 : 32'd0, c);
            step();
        end
        en = 1'b0;
        step();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
